// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: steps an analog mux over the enabled channels, lets each
// one settle, runs one conversion on the SAR core and stores the result per
// channel. Supports single-shot or continuous scans. A watchdog abandons a
// conversion that never finishes.
// Optional build macro ADC_SEQ_AVG_EN: each channel is sampled 4 times and
// the stored result is the truncated mean.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int ADC_WIDTH   = 12,
  parameter int CH_W        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           cfg_ch_mask,
  input  logic                        cfg_continuous,
  input  logic [7:0]                  cfg_settle,
  input  logic                        scan_start,
  input  logic                        scan_stop,
  output logic                        adc_start,
  input  logic                        adc_busy,
  input  logic                        adc_eoc,
  input  logic [ADC_WIDTH-1:0]        adc_data,
  output logic [CH_W-1:0]             mux_sel,
  output logic [NUM_CH*ADC_WIDTH-1:0] result_data,
  output logic [NUM_CH-1:0]           result_valid,
  output logic                        scan_done,
  output logic                        seq_busy,
  output logic                        timeout_err
);

  // Counter wide enough to reach TIMEOUT_CYC-1; the +1 keeps TIMEOUT_CYC=1 legal.
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_CONVERT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [CH_W-1:0]                     ch_q, ch_d;
  logic [NUM_CH-1:0]                   mask_q, mask_d;
  logic [7:0]                          settle_q, settle_d;
  logic [TW-1:0]                       tmo_q, tmo_d;
  logic [ADC_WIDTH-1:0]                data_q, data_d;
  logic [NUM_CH-1:0][ADC_WIDTH-1:0]    res_q, res_d;
  logic [NUM_CH-1:0]                   valid_q, valid_d;
  logic                                terr_q, terr_d;
  logic                                stop_q, stop_d;
`ifdef ADC_SEQ_AVG_EN
  logic [ADC_WIDTH+1:0]                acc_q, acc_d;
  logic [1:0]                          samp_q, samp_d;
  logic [ADC_WIDTH+1:0]                acc_sum;
`endif

  logic [CH_W-1:0] first_ch;
  logic [CH_W-1:0] nxt_ch;
  logic            nxt_found;
  logic            tmo_hit;
  logic            stop_now;

  // Lowest enabled channel of the live config mask (scan entry / restart).
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (cfg_ch_mask[i]) first_ch = CH_W'(i);
  end

  // Next enabled channel above the current one in the latched mask; no wrap.
  always_comb begin
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch    = CH_W'(i);
        nxt_found = 1'b1;
      end
  end

  assign tmo_hit  = (tmo_q == TMO_LAST);
  // A stop seen during a conversion is deferred until the channel finishes.
  assign stop_now = stop_q | scan_stop;

`ifdef ADC_SEQ_AVG_EN
  assign acc_sum = acc_q + {2'b00, data_q};
`endif

  // Next-state and datapath updates for the scan FSM.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    res_d    = res_q;
    valid_d  = valid_q;
    terr_d   = terr_q;
    stop_d   = stop_q;
`ifdef ADC_SEQ_AVG_EN
    acc_d    = acc_q;
    samp_d   = samp_q;
`endif
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (scan_start && !scan_stop && (cfg_ch_mask != '0)) begin
          mask_d  = cfg_ch_mask;
          valid_d = '0;
          terr_d  = 1'b0;
          ch_d    = first_ch;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        settle_d = cfg_settle;
        if (scan_stop) state_d = S_IDLE;
        else if (cfg_settle == 8'd0) begin
          // No settle requested: go straight to the conversion request.
          tmo_d   = '0;
`ifdef ADC_SEQ_AVG_EN
          acc_d   = '0;
          samp_d  = '0;
`endif
          state_d = S_START;
        end else state_d = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (scan_stop) state_d = S_IDLE;
        else if (settle_d == 8'd0) begin
          tmo_d   = '0;
`ifdef ADC_SEQ_AVG_EN
          acc_d   = '0;
          samp_d  = '0;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d = tmo_q + 1'b1;
        if (scan_stop) state_d = S_IDLE;
        else if (tmo_hit) begin
          terr_d  = 1'b1;
          state_d = stop_q ? S_IDLE : S_NEXT;
        end else if (adc_busy) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        tmo_d = tmo_q + 1'b1;
        if (scan_stop) stop_d = 1'b1;
        if (adc_eoc) begin
          data_d  = adc_data;
          state_d = S_STORE;
        end else if (tmo_hit) begin
          terr_d  = 1'b1;
          state_d = stop_now ? S_IDLE : S_NEXT;
        end
      end
      S_STORE: begin
        if (scan_stop) stop_d = 1'b1;
`ifdef ADC_SEQ_AVG_EN
        if (samp_q == 2'd3) begin
          res_d[ch_q]   = acc_sum[ADC_WIDTH+1:2];
          valid_d[ch_q] = 1'b1;
          state_d       = stop_now ? S_IDLE : S_NEXT;
        end else begin
          // Back-to-back resample on the same channel, no re-settle.
          acc_d   = acc_sum;
          samp_d  = samp_q + 2'd1;
          tmo_d   = '0;
          state_d = S_START;
        end
`else
        res_d[ch_q]   = data_q;
        valid_d[ch_q] = 1'b1;
        state_d       = stop_now ? S_IDLE : S_NEXT;
`endif
      end
      S_NEXT: begin
        if (scan_stop) state_d = S_IDLE;
        else if (nxt_found) begin
          ch_d    = nxt_ch;
          state_d = S_SELECT;
        end else state_d = S_DONE;
      end
      S_DONE: begin
        if (scan_stop) state_d = S_IDLE;
        else if (cfg_continuous) begin
          mask_d  = cfg_ch_mask;
          valid_d = '0;
          if (cfg_ch_mask != '0) begin
            ch_d    = first_ch;
            state_d = S_SELECT;
          end else state_d = S_IDLE;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset clears every output source.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      mask_q   <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      res_q    <= '0;
      valid_q  <= '0;
      terr_q   <= 1'b0;
      stop_q   <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc_q    <= '0;
      samp_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
      stop_q   <= stop_d;
`ifdef ADC_SEQ_AVG_EN
      acc_q    <= acc_d;
      samp_q   <= samp_d;
`endif
    end
  end

  assign adc_start    = (state_q == S_START);
  // A stop landing in the DONE cycle suppresses the completion pulse.
  assign scan_done    = (state_q == S_DONE) && !scan_stop;
  assign seq_busy     = (state_q != S_IDLE);
  assign mux_sel      = ch_q;
  assign result_data  = res_q;
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a small behavioural SAR core.
module tb_adc_scan_sequencer;

  logic        sys_clk;
  logic        reset;
  logic [3:0]  cfg_ch_mask;
  logic        cfg_continuous;
  logic [7:0]  cfg_settle;
  logic        scan_start;
  logic        scan_stop;
  logic        adc_start;
  logic        adc_busy;
  logic        adc_eoc;
  logic [11:0] adc_data;
  logic [1:0]  mux_sel;
  logic [47:0] result_data;
  logic [3:0]  result_valid;
  logic        scan_done;
  logic        seq_busy;
  logic        timeout_err;

  adc_scan_sequencer #(.NUM_CH(4), .ADC_WIDTH(12), .CH_W(2), .TIMEOUT_CYC(4096)) dut (
    .sys_clk(sys_clk), .reset(reset), .cfg_ch_mask(cfg_ch_mask),
    .cfg_continuous(cfg_continuous), .cfg_settle(cfg_settle),
    .scan_start(scan_start), .scan_stop(scan_stop), .adc_start(adc_start),
    .adc_busy(adc_busy), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .mux_sel(mux_sel), .result_data(result_data), .result_valid(result_valid),
    .scan_done(scan_done), .seq_busy(seq_busy), .timeout_err(timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] slot(input int i);
    return result_data[i*12 +: 12];
  endfunction

  // ADC model knobs
  int          hang_ch   = 99;
  logic [11:0] data_base = 12'h100;
  int          avg_mode  = 0;
  int          avg_idx   = 0;
  logic [11:0] avg_tbl [4];

  // Behavioural SAR core: busy one negedge after start, eoc 4 cycles later.
  initial begin : adc_model
    int cnt;
    int ch;
    cnt = 0; ch = 0;
    adc_busy = 1'b0; adc_eoc = 1'b0; adc_data = '0;
    forever begin
      @(negedge sys_clk);
      adc_eoc = 1'b0;
      if (!adc_busy) begin
        if (adc_start) begin
          adc_busy = 1'b1; cnt = 3; ch = int'(mux_sel);
        end
      end else if (!seq_busy) adc_busy = 1'b0;
      else if (ch != hang_ch) begin
        if (cnt == 0) begin
          adc_busy = 1'b0;
          adc_eoc  = 1'b1;
          if (avg_mode != 0) begin
            adc_data = avg_tbl[avg_idx % 4];
            avg_idx++;
          end else adc_data = data_base + 12'(ch);
        end else cnt--;
      end
    end
  end

  // Observers
  int   done_cnt = 0;
  int   start_cnt = 0;
  int   visits[$];
  logic prev_start = 1'b0;
  bit   lat_arm = 1'b0;
  int   lat_cnt = 0;
  int   lat = -1;

  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      #1;
      if (scan_done) done_cnt++;
      if (adc_start && !prev_start) begin
        start_cnt++;
        if (visits.size() == 0 || visits[visits.size()-1] != int'(mux_sel))
          visits.push_back(int'(mux_sel));
      end
      prev_start = adc_start;
      if (lat_arm) begin
        if (adc_start) begin lat = lat_cnt; lat_arm = 1'b0; end
        else if (seq_busy) lat_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_start();
    @(negedge sys_clk); scan_start = 1'b1;
    @(negedge sys_clk); scan_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (seq_busy && k < budget) begin @(negedge sys_clk); #2; k++; end
    chk(tag, seq_busy, 0);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int k;
    k = 0;
    while (!adc_busy && k < budget) begin @(negedge sys_clk); #2; k++; end
    chk(tag, adc_busy, 1);
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int exp_v [3];
    int k;
    exp_v = '{0, 1, 3};
    reset = 1'b1; cfg_ch_mask = '0; cfg_continuous = 1'b0; cfg_settle = '0;
    scan_start = 1'b0; scan_stop = 1'b0;
    avg_tbl = '{12'h0FF, 12'h100, 12'h101, 12'h103};
    cyc(3);
    reset = 1'b0;
    #2;
    chk("rst_mux", mux_sel, 0);
    chk("rst_data", result_data, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_terr", timeout_err, 0);

    // 1: basic single-shot scan over channels 0,1,3
    cfg_ch_mask = 4'b1011; cfg_settle = 8'd3;
    visits.delete(); done_cnt = 0; lat_cnt = 0; lat = -1; lat_arm = 1'b1;
    pulse_start();
    wait_idle(300, "t1_idle");
    cyc(2); #2;
    chk("t1_latency", lat, 4);
    chk("t1_nvisit", visits.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t1_visit", (i < visits.size()) ? visits[i] : -1, exp_v[i]);
    chk("t1_slot0", slot(0), 12'h100);
    chk("t1_slot1", slot(1), 12'h101);
    chk("t1_slot2", slot(2), 12'h000);
    chk("t1_slot3", slot(3), 12'h103);
    chk("t1_valid", result_valid, 4'b1011);
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", seq_busy, 0);
    chk("t1_terr", timeout_err, 0);

    // 2: empty mask ignored; start+stop together also ignored
    cfg_ch_mask = 4'b0000; k = start_cnt;
    pulse_start();
    cyc(5); #2;
    chk("t2_busy", seq_busy, 0);
    chk("t2_nostart", start_cnt, k);
    cfg_ch_mask = 4'b0001;
    @(negedge sys_clk); scan_start = 1'b1; scan_stop = 1'b1;
    @(negedge sys_clk); scan_start = 1'b0; scan_stop = 1'b0;
    #2;
    chk("t2_stopwins", seq_busy, 0);

    // 3: channel 1 hangs -> watchdog
    hang_ch = 1; cfg_ch_mask = 4'b0011; cfg_settle = 8'd0; done_cnt = 0;
    pulse_start();
    cyc(4050); #2;
    chk("t3_early_terr", timeout_err, 0);
    chk("t3_early_busy", seq_busy, 1);
    wait_idle(400, "t3_idle");
    cyc(2); #2;
    chk("t3_terr", timeout_err, 1);
    chk("t3_valid", result_valid, 4'b0001);
    chk("t3_slot0", slot(0), 12'h100);
    chk("t3_slot1_kept", slot(1), 12'h101);
    chk("t3_done", done_cnt, 1);
    hang_ch = 99;

    // 4: continuous mode, 3 scans, then stop during CONVERT
    cfg_ch_mask = 4'b0100; cfg_settle = 8'd2; cfg_continuous = 1'b1; done_cnt = 0;
    pulse_start();
    k = 0;
    while (done_cnt < 3 && k < 400) begin @(negedge sys_clk); #2; k++; end
    chk("t4_done3", done_cnt, 3);
    chk("t4_terr_clr", timeout_err, 0);
    data_base = 12'h200;
    wait_busy(60, "t4_busy");
    @(negedge sys_clk); scan_stop = 1'b1;
    @(negedge sys_clk); scan_stop = 1'b0;
    wait_idle(100, "t4_idle");
    cyc(4); #2;
    chk("t4_no4th", done_cnt, 3);
    chk("t4_valid", result_valid, 4'b0100);
    chk("t4_slot2", slot(2), 12'h202);
    cfg_continuous = 1'b0; data_base = 12'h100;

    // 5a: stop during SETTLE
    cfg_ch_mask = 4'b0001; cfg_settle = 8'd8; k = start_cnt; done_cnt = 0;
    pulse_start();
    cyc(2); scan_stop = 1'b1;
    @(negedge sys_clk); scan_stop = 1'b0;
    #2;
    chk("t5_idle_next", seq_busy, 0);
    cyc(12); #2;
    chk("t5_nostart", start_cnt, k);
    chk("t5_nodone", done_cnt, 0);

    // 5b: async reset while converting
    cfg_ch_mask = 4'b0100; cfg_settle = 8'd1;
    pulse_start();
    wait_busy(60, "t5_busy");
    @(negedge sys_clk);
    #1;
    chk("t5_pre_busy", seq_busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_mux", mux_sel, 0);
    chk("t5_rst_data", result_data, 0);
    chk("t5_rst_valid", result_valid, 0);
    chk("t5_rst_start", adc_start, 0);
    chk("t5_rst_busy", seq_busy, 0);
    chk("t5_rst_done", scan_done, 0);
    chk("t5_rst_terr", timeout_err, 0);
    @(negedge sys_clk); reset = 1'b0;
    cyc(3);

`ifdef ADC_SEQ_AVG_EN
    // 6: four-sample average on channel 2
    avg_mode = 1; avg_idx = 0; cfg_ch_mask = 4'b0100; cfg_settle = 8'd0;
    pulse_start();
    wait_idle(200, "t6_idle");
    #2;
    chk("t6_slot2", slot(2), 12'h100);
    chk("t6_valid", result_valid, 4'b0100);
    chk("t6_samples", avg_idx, 4);
    avg_mode = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Multi-channel scan sequencer that sits in front of the SAR ADC core's start/busy/EOC interface.
- Drives an external analog mux select.
- Waits a programmable settle time, then requests one conversion per enabled channel.
- Stores per-channel results in output registers.
- Signals end-of-scan.
- Supports single-shot and continuous scanning, with a watchdog for conversions that hang.

Parameters:
NUM_CH, 4, number of analog mux channels (2..16)
ADC_WIDTH, 12, ADC result width
CH_W, 2, mux select width; must equal ceil(log2(NUM_CH))
TIMEOUT_CYC, 4096, max sys_clk cycles from adc_start assertion to adc_eoc before abandoning the channel

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_ch_mask  in  NUM_CH  channel enable mask; bit i enables channel i
cfg_continuous  in  1  1 = restart scan automatically after done
cfg_settle  in  8  mux settle time in sys_clk cycles (0 allowed)
scan_start  in  1  one-cycle pulse; begins a scan
scan_stop  in  1  one-cycle pulse; aborts/ends scanning
adc_start  out  1  conversion request level to ADC core
adc_busy  in  1  ADC core converting
adc_eoc  in  1  one-sys_clk end-of-conversion pulse (already synchronised)
adc_data  in  ADC_WIDTH  conversion result, valid with adc_eoc
mux_sel  out  CH_W  analog mux channel select
result_data  out  NUM_CH*ADC_WIDTH  channel i result at bits [i*ADC_WIDTH +: ADC_WIDTH]
result_valid  out  NUM_CH  bit i set when channel i was stored this scan
scan_done  out  1  one-cycle pulse at scan completion
seq_busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky; a channel conversion timed out

Behaviour:
- Reset values: all outputs 0. This includes mux_sel, result_data, result_valid, adc_start, scan_done, seq_busy and timeout_err. FSM goes to IDLE.
- States: IDLE, SELECT, SETTLE, START, CONVERT, STORE, NEXT, DONE.
- IDLE: on scan_start with cfg_ch_mask != 0:
  - latch the mask
  - clear result_valid and timeout_err
  - go to SELECT with the lowest enabled channel
  - scan_start with mask == 0 is ignored
- SELECT (1 cycle): drive mux_sel, load settle counter with cfg_settle, go to SETTLE.
- SETTLE: decrement; exit to START when counter == 0. cfg_settle=0 gives zero extra cycles.
- START: assert adc_start and start the timeout counter; go to CONVERT when adc_busy=1.
- CONVERT: deassert adc_start on entry; wait for adc_eoc.
- adc_start stays high across START until adc_busy is seen.
- STORE (1 cycle after adc_eoc cycle):
  - write the adc_data captured in the eoc cycle to that channel's slot
  - set its result_valid bit
- NEXT: pick the next higher enabled channel of the latched mask. Found → SELECT. None → DONE. Channels are visited in ascending order; no wrap within a scan.
- DONE: pulse scan_done for 1 cycle. If cfg_continuous=1, re-latch cfg_ch_mask and clear result_valid, then go to SELECT (or IDLE if mask is now 0). Otherwise go to IDLE.
- Timeout: if adc_eoc has not arrived TIMEOUT_CYC cycles after entering START:
  - set timeout_err
  - deassert adc_start
  - leave the channel's result and valid bit unchanged
  - go to NEXT
- scan_stop:
  - In IDLE/SELECT/SETTLE/START/NEXT/DONE: go to IDLE next cycle, drop adc_start, no scan_done.
  - In CONVERT: finish the conversion (store on eoc, or timeout), then go to IDLE with no scan_done.
- adc_eoc outside CONVERT is ignored.
- scan_start while not IDLE is ignored.
- Simultaneous scan_start and scan_stop in IDLE: stop wins; remain IDLE.
- result_data persists until overwritten; mux_sel holds its last value in IDLE.
- Async reset mid-scan returns everything to reset values immediately.

Optional Feature:
Macro ADC_SEQ_AVG_EN.
- Defined: each channel is converted 4 times back-to-back without re-settling (STORE loops to START until 4 samples).
  - Samples accumulate in an ADC_WIDTH+2 bit register.
  - Stored result = sum >> 2, truncated.
  - A timeout on any sample abandons the channel: no store, timeout_err set.
- Undefined: a single conversion per channel; the accumulator logic is absent.

Test Plan:
1. Reset, mask=4'b1011, settle=3, scan_start; ADC model returns 0x100+ch. Required: mux_sel visits 0,1,3; result slots 0/1/3 = 0x100/0x101/0x103; result_valid=4'b1011; one scan_done pulse; seq_busy low afterwards.
2. mask=0 with scan_start → stays IDLE, seq_busy=0, no adc_start.
3. ADC model never asserts eoc on channel 1, mask=4'b0011 → timeout_err=1 after 4096 cycles. Channel 0 stored; result_valid=4'b0001; scan_done still pulses.
4. cfg_continuous=1, mask=4'b0100, 3 scans → 3 scan_done pulses. Then scan_stop during CONVERT → conversion stored, IDLE, no 4th scan_done.
5. scan_stop during SETTLE → adc_start never asserted, IDLE next cycle. Separately, reset asserted mid-CONVERT → all outputs 0 immediately.
6. With ADC_SEQ_AVG_EN: channel 2 samples 0x0FF, 0x100, 0x101, 0x103 → stored 0x100 (sum 0x403 >> 2).
